// File: rtl/reset_sequencer_pkg.sv
// Shared types and constants for the reset sequencer: FSM states, Avalon
// register map and reset-cause bit positions.
package reset_sequencer_pkg;

    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        STAGGER = 2'd1,
        RUN     = 2'd2
    } seq_state_e;

    localparam logic [15:0] SW_RESET_KEY = 16'hA5A5;

    localparam logic [1:0] ADDR_CAUSE = 2'd0;
    localparam logic [1:0] ADDR_SWRST = 2'd1;
    localparam logic [1:0] ADDR_COUNT = 2'd2;

    localparam int SW_BIT  = 8;
    localparam int POR_BIT = 15;

    localparam logic [15:0] CAUSE_RESET_VAL = 16'h8000;
    localparam logic [15:0] COUNT_MAX       = 16'hFFFF;

endpackage

// File: rtl/reset_seq_fsm.sv
// Sequencing core: holds both resets low for a minimum time, releases the
// peripheral reset first and the CPU reset a few cycles later.
module reset_seq_fsm
    import reset_sequencer_pkg::*;
#(
    parameter int HOLD_CYCLES    = 16,
    parameter int STAGGER_CYCLES = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic req_any_i,
    output logic sys_reset_n_o,
    output logic cpu_reset_n_o,
    output logic assert_entry_o
);

    localparam int MAX_CYCLES = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sys_reset_n_q, cpu_reset_n_q;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        assert_entry_o = 1'b0;
        case (state_q)
            ASSERT: begin
                // Any request restarts the minimum hold window.
                if (req_any_i) begin
                    cnt_d = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = STAGGER;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STAGGER: begin
                if (req_any_i) begin
                    state_d        = ASSERT;
                    cnt_d          = '0;
                    assert_entry_o = 1'b1;
                end else if (cnt_q == STAGGER_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            RUN: begin
                if (req_any_i) begin
                    state_d        = ASSERT;
                    cnt_d          = '0;
                    assert_entry_o = 1'b1;
                end
            end
            default: begin
                state_d = ASSERT;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ASSERT;
            cnt_q         <= '0;
            sys_reset_n_q <= 1'b0;
            cpu_reset_n_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sys_reset_n_q <= (state_d != ASSERT);
            cpu_reset_n_q <= (state_d == RUN);
        end
    end

    assign sys_reset_n_o = sys_reset_n_q;
    assign cpu_reset_n_o = cpu_reset_n_q;

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer top: request merging, Avalon-MM cause/count registers and
// the sequencing core. Registers here survive the resets this block generates.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int HOLD_CYCLES    = 16,
    parameter int STAGGER_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] reset_req,
    input  logic [1:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    output logic               sys_reset_n,
    output logic               cpu_reset_n
);

    logic        wr_en;
    logic        sw_key;
    logic        req_any;
    logic        assert_entry;
    logic [15:0] cause_q, cause_d;
    logic [15:0] count_q, count_d;
    logic [15:0] readdata_q, readdata_d;
    logic [15:0] cause_set, cause_clr;

    assign wr_en   = chipselect & ~write_n;
    assign sw_key  = wr_en && (address == ADDR_SWRST) && (writedata == SW_RESET_KEY);
    assign req_any = (|reset_req) | sw_key;

    reset_seq_fsm #(
        .HOLD_CYCLES    (HOLD_CYCLES),
        .STAGGER_CYCLES (STAGGER_CYCLES)
    ) u_fsm (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_any_i      (req_any),
        .sys_reset_n_o  (sys_reset_n),
        .cpu_reset_n_o  (cpu_reset_n),
        .assert_entry_o (assert_entry)
    );

    // Cause bits are sticky; a simultaneous set beats a software clear.
    always_comb begin
        cause_set                = '0;
        cause_set[NUM_REQ-1:0]   = reset_req;
        cause_set[SW_BIT]        = sw_key;
        cause_clr                = (wr_en && (address == ADDR_CAUSE)) ? writedata : 16'h0000;
        cause_d                  = (cause_q & ~cause_clr) | cause_set;
    end

    // A software clear of the count beats a simultaneous increment.
    always_comb begin
        count_d = count_q;
        if (wr_en && (address == ADDR_COUNT)) begin
            count_d = 16'h0000;
        end else if (assert_entry && (count_q != COUNT_MAX)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_comb begin
        readdata_d = 16'h0000;
        case (address)
            ADDR_CAUSE: readdata_d = cause_q;
            ADDR_COUNT: readdata_d = count_q;
            default:    readdata_d = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cause_q    <= CAUSE_RESET_VAL;
            count_q    <= 16'h0000;
            readdata_q <= 16'h0000;
        end else begin
            cause_q    <= cause_d;
            count_q    <= count_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: POR timing, request stretching,
// software key, stagger re-entry, register precedence and count saturation.
module tb_reset_sequencer;

    localparam int HOLD    = 16;
    localparam int STAGGER = 4;

    logic        clk;
    logic        reset_n;
    logic [1:0]  reset_req;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        sys_reset_n;
    logic        cpu_reset_n;

    int testCount;
    int failCount;

    reset_sequencer #(
        .NUM_REQ        (2),
        .HOLD_CYCLES    (HOLD),
        .STAGGER_CYCLES (STAGGER)
    ) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .reset_req   (reset_req),
        .address     (address),
        .chipselect  (chipselect),
        .write_n     (write_n),
        .writedata   (writedata),
        .readdata    (readdata),
        .sys_reset_n (sys_reset_n),
        .cpu_reset_n (cpu_reset_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic avalonWrite(input logic [1:0] addr, input logic [15:0] data);
        address    = addr;
        writedata  = data;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic avalonRead(input logic [1:0] addr, output logic [15:0] data);
        address = addr;
        tick();
        data = readdata;
    endtask

    // Called just after the last edge that sampled a request; the next edge is m.
    task automatic checkRelease(input string tag);
        repeat (HOLD - 1) tick();
        checkOutput({tag, "_sys_still_low"}, {15'd0, sys_reset_n}, 16'd0);
        tick();
        checkOutput({tag, "_sys_high"}, {15'd0, sys_reset_n}, 16'd1);
        checkOutput({tag, "_cpu_low"}, {15'd0, cpu_reset_n}, 16'd0);
        repeat (STAGGER - 1) tick();
        checkOutput({tag, "_cpu_still_low"}, {15'd0, cpu_reset_n}, 16'd0);
        tick();
        checkOutput({tag, "_cpu_high"}, {15'd0, cpu_reset_n}, 16'd1);
    endtask

    task automatic applyStimulus(input logic [1:0] req);
        reset_req = req;
        tick();
        reset_req = 2'b00;
    endtask

    task automatic waitRun(input string tag);
        int budget;
        budget = 0;
        while (cpu_reset_n !== 1'b1 && budget < 100) begin
            tick();
            budget++;
        end
        checkOutput({tag, "_run_reached"}, {15'd0, cpu_reset_n}, 16'd1);
    endtask

    initial begin
        logic [15:0] rd;
        testCount  = 0;
        failCount  = 0;
        reset_n    = 1'b0;
        reset_req  = 2'b00;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 16'h0000;

        #12;
        checkOutput("por_sys", {15'd0, sys_reset_n}, 16'd0);
        checkOutput("por_cpu", {15'd0, cpu_reset_n}, 16'd0);
        checkOutput("por_readdata", readdata, 16'h0000);
        tick();
        reset_n = 1'b1;
        checkRelease("por");
        avalonRead(2'd0, rd);
        checkOutput("por_cause", rd, 16'h8000);
        avalonRead(2'd2, rd);
        checkOutput("por_count", rd, 16'h0000);

        applyStimulus(2'b01);
        checkOutput("pulse_assert", {14'd0, sys_reset_n, cpu_reset_n}, 16'd0);
        checkRelease("pulse");
        avalonRead(2'd0, rd);
        checkOutput("pulse_cause", rd, 16'h8001);
        avalonRead(2'd2, rd);
        checkOutput("pulse_count", rd, 16'h0001);
        avalonWrite(2'd0, 16'hFFFF);
        avalonRead(2'd0, rd);
        checkOutput("cause_cleared", rd, 16'h0000);

        reset_req = 2'b10;
        for (int i = 0; i < 50; i++) begin
            tick();
            checkOutput("held_low", {14'd0, sys_reset_n, cpu_reset_n}, 16'd0);
        end
        reset_req = 2'b00;
        checkRelease("held");
        avalonRead(2'd0, rd);
        checkOutput("held_cause", rd, 16'h0002);
        avalonRead(2'd2, rd);
        checkOutput("held_count", rd, 16'h0002);
        avalonWrite(2'd0, 16'hFFFF);

        avalonWrite(2'd1, 16'h1234);
        checkOutput("badkey_no_reset", {14'd0, sys_reset_n, cpu_reset_n}, 16'd3);
        repeat (2) tick();
        checkOutput("badkey_still_run", {14'd0, sys_reset_n, cpu_reset_n}, 16'd3);
        avalonRead(2'd1, rd);
        checkOutput("swrst_reads_zero", rd, 16'h0000);
        avalonRead(2'd3, rd);
        checkOutput("addr3_reads_zero", rd, 16'h0000);
        avalonWrite(2'd1, 16'hA5A5);
        checkOutput("swkey_assert", {14'd0, sys_reset_n, cpu_reset_n}, 16'd0);
        checkRelease("swkey");
        avalonRead(2'd0, rd);
        checkOutput("swkey_cause", rd, 16'h0100);
        avalonRead(2'd2, rd);
        checkOutput("swkey_count", rd, 16'h0003);
        avalonWrite(2'd0, 16'h8100);
        avalonRead(2'd0, rd);
        checkOutput("cause_8100_clear", rd, 16'h0000);

        applyStimulus(2'b01);
        repeat (HOLD) tick();
        checkOutput("stag_enter", {14'd0, sys_reset_n, cpu_reset_n}, 16'd2);
        tick();
        applyStimulus(2'b01);
        checkOutput("stag_reassert", {14'd0, sys_reset_n, cpu_reset_n}, 16'd0);
        checkRelease("stag");
        avalonRead(2'd2, rd);
        checkOutput("stag_count", rd, 16'h0005);

        reset_req  = 2'b01;
        address    = 2'd2;
        writedata  = 16'h0000;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        reset_req  = 2'b00;
        checkRelease("cnt_prec");
        avalonRead(2'd2, rd);
        checkOutput("count_clear_wins", rd, 16'h0000);

        reset_req  = 2'b01;
        address    = 2'd0;
        writedata  = 16'hFFFF;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        reset_req  = 2'b00;
        checkRelease("cause_prec");
        avalonRead(2'd0, rd);
        checkOutput("cause_set_wins", rd, 16'h0001);
        avalonRead(2'd2, rd);
        checkOutput("count_after_prec", rd, 16'h0001);

        force u_dut.count_d = 16'hFFFC;
        tick();
        release u_dut.count_d;
        repeat (2) begin
            applyStimulus(2'b01);
            waitRun("sat_a");
        end
        avalonRead(2'd2, rd);
        checkOutput("count_fffe", rd, 16'hFFFE);
        repeat (3) begin
            applyStimulus(2'b10);
            waitRun("sat_b");
        end
        avalonRead(2'd2, rd);
        checkOutput("count_saturated", rd, 16'hFFFF);

        applyStimulus(2'b01);
        repeat (HOLD + 1) tick();
        reset_n = 1'b0;
        #1;
        checkOutput("mid_por_outputs", {14'd0, sys_reset_n, cpu_reset_n}, 16'd0);
        checkOutput("mid_por_readdata", readdata, 16'h0000);
        tick();
        reset_n = 1'b1;
        checkRelease("mid_por");
        avalonRead(2'd0, rd);
        checkOutput("mid_por_cause", rd, 16'h8000);
        avalonRead(2'd2, rd);
        checkOutput("mid_por_count", rd, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
